// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: access-size codes,
// FSM state encoding and requester identifiers.
// No logic here; imported by dm_port_arbiter and dm_lane_steer.
package dm_port_arbiter_pkg;

  // CPU access-size codes carried on cpu_type.
  localparam logic [2:0] SZ_WORD = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_BYTE = 3'd2;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

  // Requester identity, used both for the current owner and for last_grant.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } dm_owner_t;

  // Word-aligned byte offset of a lane: lane n starts at bit 8*n.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/dm_lane_steer.sv
// CPU store lane steering: size/addr/wdata/irq -> byte enables, lane data, misalignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, consumed by the arbiter at accept.
module dm_lane_steer
  import dm_port_arbiter_pkg::*;
(
  input  logic [2:0]  size,        // SZ_WORD / SZ_HALF / SZ_BYTE, anything else unknown
  input  logic [1:0]  addr_lo,     // byte offset within the word
  input  logic [31:0] wdata,       // right-aligned store data
  input  logic        we,          // 1 = store; loads never enable lanes
  input  logic        irq_cancel,  // pending interrupt suppresses store lanes
  output logic [3:0]  lane_byteen,
  output logic [31:0] lane_wdata,
  output logic        misaligned
);

  // Decode size and offset into lane enables and shifted data.
  always_comb begin
    lane_byteen = 4'b0000;
    lane_wdata  = wdata;
    misaligned  = 1'b0;
    case (size)
      SZ_WORD: begin
        lane_byteen = 4'b1111;
        misaligned  = |addr_lo;
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        if (addr_lo[1]) begin
          lane_byteen = 4'b1100;
          lane_wdata  = {wdata[15:0], 16'h0000};
        end else begin
          lane_byteen = 4'b0011;
          lane_wdata  = {16'h0000, wdata[15:0]};
        end
      end
      SZ_BYTE: begin
        lane_byteen = 4'b0001 << addr_lo;
        lane_wdata  = {24'h000000, wdata[7:0]} << lane_shift(addr_lo);
      end
      default: begin
        lane_byteen = 4'b0000;
        lane_wdata  = wdata;
      end
    endcase
    // Loads write nothing; an interrupt at accept turns the store into a
    // no-op write while keeping the memory handshake intact.
    if (!we || irq_cancel) begin
      lane_byteen = 4'b0000;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and the DMA port (optional DM_TIMEOUT_EN).
// Latency: min 3 cycles per access (accept, BUSY with mem_ready, RESP pulse); misaligned CPU = 2.
// Backpressure: requesters hold valid until their ready/exc pulse; memory stalls BUSY via mem_ready.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // CPU MEM stage
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_type,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_irq_req,
  output logic              cpu_ready,
  output logic              cpu_exc,
  output logic [31:0]       cpu_rdata,
  // DMA / bridge port, word accesses only
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  // Data memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              timeout_err
);

  dm_state_t   state;
  dm_owner_t   owner;
  dm_owner_t   last_grant;
  logic        grant_cpu;
  logic        grant_dma;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic        unused_sig;

  dm_lane_steer u_lane_steer (
    .size        (cpu_type),
    .addr_lo     (cpu_addr[1:0]),
    .wdata       (cpu_wdata),
    .we          (cpu_we),
    .irq_cancel  (cpu_irq_req),
    .lane_byteen (st_byteen),
    .lane_wdata  (st_wdata),
    .misaligned  (st_misaligned)
  );

`ifdef DM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] tmo_cnt;
  logic            tmo_err_q;

  assign timeout_err = tmo_err_q;
  // DMA low address bits are don't-care: DMA is word-only.
  assign unused_sig  = ^dma_addr[1:0];
`else
  assign timeout_err = 1'b0;
  // Without the watchdog the limit has no consumer.
  assign unused_sig  = ^{dma_addr[1:0], (TIMEOUT_CYCLES > 0)};
`endif

  // Round-robin pick in IDLE: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == ST_IDLE) begin
      if (cpu_valid && (!dma_valid || (last_grant == OWN_DMA))) begin
        grant_cpu = 1'b1;
      end else if (dma_valid) begin
        grant_dma = 1'b1;
      end
    end
  end

  // Access sequencer: latches the winning request, drives the memory handshake, pulses completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_DMA;
      cpu_ready  <= 1'b0;
      cpu_exc    <= 1'b0;
      cpu_rdata  <= 32'h0;
      dma_ready  <= 1'b0;
      dma_rdata  <= 32'h0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      mem_byteen <= 4'b0000;
`ifdef DM_TIMEOUT_EN
      tmo_cnt    <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_cpu) begin
            last_grant <= OWN_CPU;
            owner      <= OWN_CPU;
            if (st_misaligned) begin
              // Fault is reported without touching memory.
              cpu_exc <= 1'b1;
              state   <= ST_RESP;
            end else begin
              mem_en     <= 1'b1;
              mem_we     <= cpu_we;
              mem_addr   <= {cpu_addr[ADDR_W-1:2], 2'b00};
              mem_wdata  <= st_wdata;
              mem_byteen <= st_byteen;
              state      <= ST_BUSY;
`ifdef DM_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end else if (grant_dma) begin
            last_grant <= OWN_DMA;
            owner      <= OWN_DMA;
            mem_en     <= 1'b1;
            mem_we     <= dma_we;
            mem_addr   <= {dma_addr[ADDR_W-1:2], 2'b00};
            mem_wdata  <= dma_wdata;
            mem_byteen <= dma_we ? 4'b1111 : 4'b0000;
            state      <= ST_BUSY;
`ifdef DM_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end

        ST_BUSY: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_RESP;
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_rdata;
              cpu_ready <= 1'b1;
            end else begin
              dma_rdata <= mem_rdata;
              dma_ready <= 1'b1;
            end
          end
`ifdef DM_TIMEOUT_EN
          else if (tmo_cnt == TO_LAST) begin
            // Memory never answered: abandon the cycle and complete with zero data.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            tmo_err_q <= 1'b1;
            state     <= ST_RESP;
            if (owner == OWN_CPU) begin
              cpu_rdata <= 32'h0;
              cpu_ready <= 1'b1;
            end else begin
              dma_rdata <= 32'h0;
              dma_ready <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          // Pulses last exactly one cycle; requesters re-arbitrate from IDLE.
          cpu_ready <= 1'b0;
          cpu_exc   <= 1'b0;
          dma_ready <= 1'b0;
`ifdef DM_TIMEOUT_EN
          tmo_err_q <= 1'b0;
`endif
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: reset, fairness, lane steering, irq cancel,
// misalignment, delayed memory, async reset abort and (with DM_TIMEOUT_EN) timeout.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid, cpu_we, cpu_irq_req;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_exc;
  logic [31:0] cpu_rdata;
  logic        dma_valid, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ready;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int overlap  = 0;

  dm_port_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_type    (cpu_type),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_irq_req (cpu_irq_req),
    .cpu_ready   (cpu_ready),
    .cpu_exc     (cpu_exc),
    .cpu_rdata   (cpu_rdata),
    .dma_valid   (dma_valid),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ready   (dma_ready),
    .dma_rdata   (dma_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byteen  (mem_byteen),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Both ready pulses high at once is never legal; tallied on the falling edge.
  always @(negedge clk) begin
    if (cpu_ready && dma_ready) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    cpu_valid   = 1'b0; cpu_we = 1'b0; cpu_type = SZ_WORD; cpu_addr = 32'h0;
    cpu_wdata   = 32'h0; cpu_irq_req = 1'b0;
    dma_valid   = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    mem_ready   = 1'b0; mem_rdata = 32'h0;
    cycle(); cycle();

    // Reset state
    check("rst_mem_en",    32'(mem_en),      32'h0);
    check("rst_cpu_ready", 32'(cpu_ready),   32'h0);
    check("rst_dma_ready", 32'(dma_ready),   32'h0);
    check("rst_cpu_exc",   32'(cpu_exc),     32'h0);
    check("rst_byteen",    32'(mem_byteen),  32'h0);
    check("rst_tmo",       32'(timeout_err), 32'h0);
    reset_n = 1'b1;
    cycle();

    // Fairness: both continuously valid, memory answers at once -> CPU, DMA, CPU, DMA
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_type = SZ_WORD; cpu_addr = 32'h100; cpu_wdata = 32'h1111_1111;
    dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h2222_2222;
    mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    for (int k = 0; k < 4; k++) begin
      cycle(); // BUSY
      check($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("rr%0d_be", k), 32'(mem_byteen), 32'hF);
      cycle(); // RESP
      check($sformatf("rr%0d_cpu_rdy", k), 32'(cpu_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr%0d_dma_rdy", k), 32'(dma_ready), (k % 2 == 0) ? 32'h0 : 32'h1);
      if (k == 3) begin
        cpu_valid = 1'b0; dma_valid = 1'b0; mem_ready = 1'b0;
      end
      cycle(); // IDLE
    end
    check("rr_cpu_rdata", cpu_rdata, 32'h5A5A_5A5A);
    check("rr_dma_rdata", dma_rdata, 32'h5A5A_5A5A);

    // CPU byte store at 0x1003
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_type = SZ_BYTE; cpu_addr = 32'h1003; cpu_wdata = 32'h0000_00AB;
    cycle(); // BUSY
    check("byte_mem_en", 32'(mem_en),     32'h1);
    check("byte_we",     32'(mem_we),     32'h1);
    check("byte_addr",   mem_addr,        32'h1000);
    check("byte_be",     32'(mem_byteen), 32'h8);
    check("byte_wdata",  mem_wdata,       32'hAB00_0000);
    check("byte_rdy_early", 32'(cpu_ready), 32'h0);
    mem_ready = 1'b1;
    cycle(); // RESP, third cycle of the access
    check("byte_rdy",    32'(cpu_ready),  32'h1);
    check("byte_en_off", 32'(mem_en),     32'h0);
    cpu_valid = 1'b0; mem_ready = 1'b0;
    cycle();
    check("byte_rdy_clr", 32'(cpu_ready), 32'h0);

    // CPU half store at 0x2002 cancelled by interrupt
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_type = SZ_HALF; cpu_addr = 32'h2002; cpu_wdata = 32'h0000_BEEF;
    cpu_irq_req = 1'b1;
    cycle(); // BUSY
    cpu_irq_req = 1'b0;
    check("irq_addr",  mem_addr,        32'h2000);
    check("irq_be",    32'(mem_byteen), 32'h0);
    check("irq_wdata", mem_wdata,       32'hBEEF_0000);
    check("irq_mem_en", 32'(mem_en),    32'h1);
    mem_ready = 1'b1;
    cycle();
    check("irq_rdy", 32'(cpu_ready), 32'h1);
    cpu_valid = 1'b0; mem_ready = 1'b0;
    cycle();

    // Misaligned word load at 0x3001
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_type = SZ_WORD; cpu_addr = 32'h3001;
    cycle(); // RESP
    check("mis_exc",    32'(cpu_exc),   32'h1);
    check("mis_mem_en", 32'(mem_en),    32'h0);
    check("mis_rdy",    32'(cpu_ready), 32'h0);
    cpu_valid = 1'b0;
    cycle();
    check("mis_exc_clr", 32'(cpu_exc), 32'h0);
    check("mis_mem_en2", 32'(mem_en),  32'h0);

    // DMA read at 0x4007 with memory answering in the sixth BUSY cycle
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 32'h4007;
    cycle(); // BUSY1
    check("dma_we", 32'(mem_we),     32'h0);
    check("dma_be", 32'(mem_byteen), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("dma_wait%0d_addr", i), mem_addr, 32'h4004);
      check($sformatf("dma_wait%0d_en", i), 32'(mem_en), 32'h1);
      cycle();
    end
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    cycle(); // RESP
    check("dma_rdy",    32'(dma_ready), 32'h1);
    check("dma_rdata",  dma_rdata,      32'h1234_5678);
    check("dma_cpu_rdy", 32'(cpu_ready), 32'h0);
    dma_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    cycle();
    check("dma_rdy_clr",  32'(dma_ready), 32'h0);
    check("dma_rdata_hold", dma_rdata,    32'h1234_5678);
    check("cpu_rdata_hold", cpu_rdata,    32'h5A5A_5A5A);

    // Asynchronous reset in the middle of a BUSY wait
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_type = SZ_WORD; cpu_addr = 32'h5000;
    cycle(); // BUSY
    check("ar_busy_en", 32'(mem_en), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_en_drop", 32'(mem_en), 32'h0);
    cpu_valid = 1'b0; mem_ready = 1'b1;
    cycle();
    check("ar_no_rdy", 32'(cpu_ready), 32'h0);
    reset_n = 1'b1; mem_ready = 1'b0;
    cycle();
    check("ar_no_rdy2", 32'(cpu_ready), 32'h0);
    check("ar_rdata",   cpu_rdata,      32'h0);

`ifdef DM_TIMEOUT_EN
    // Good load first so the zero rdata of the abort is observable
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_type = SZ_WORD; cpu_addr = 32'h6000;
    cycle();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    check("to_pre_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_valid = 1'b0; mem_ready = 1'b0;
    cycle();
    cpu_valid = 1'b1;
    cycle(); // BUSY1
    for (int i = 2; i <= 8; i++) begin
      cycle(); // BUSY2..BUSY8
      check($sformatf("to_busy%0d_en", i), 32'(mem_en), 32'h1);
    end
    check("to_no_err_yet", 32'(timeout_err), 32'h0);
    cycle(); // RESP after 8 BUSY cycles
    check("to_err",   32'(timeout_err), 32'h1);
    check("to_rdy",   32'(cpu_ready),   32'h1);
    check("to_rdata", cpu_rdata,        32'h0);
    check("to_en",    32'(mem_en),      32'h0);
    cpu_valid = 1'b0;
    cycle();
    check("to_err_clr", 32'(timeout_err), 32'h0);
`else
    check("tmo_tied_low", 32'(timeout_err), 32'h0);
`endif

    check("ready_overlap", 32'(overlap), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
